// File: rtl/scale_pkg.sv
// -----------------------------------------------------------------------------
// scale_pkg
// Shared definitions for the scale controller: display scale-mode encodings,
// default frame-buffer geometry, the commit FSM state type and the function
// that steps from one scale mode to the next.
// -----------------------------------------------------------------------------
package scale_pkg;

   // Scale-mode encodings carried on scale_out.
   localparam logic [1:0] SCALE_1X   = 2'b00;  // h, v unshifted
   localparam logic [1:0] SCALE_2X   = 2'b11;  // h>>1, v>>1
   localparam logic [1:0] SCALE_4H2V = 2'b10;  // h>>2, v>>1
   // 2'b01 is never produced; decoders treat it as SCALE_1X.

   // Default frame-buffer geometry in pixels.
   localparam int FB_WIDTH_DEF  = 240;
   localparam int FB_HEIGHT_DEF = 320;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PENDING = 2'b01,
      COMMIT  = 2'b10
   } state_t;

   // Cycle order 00 -> 11 -> 10 -> 00. The unused code behaves like 00.
   function automatic logic [1:0] next_scale(input logic [1:0] mode);
      case (mode)
         SCALE_2X:   next_scale = SCALE_4H2V;
         SCALE_4H2V: next_scale = SCALE_1X;
         default:    next_scale = SCALE_2X;
      endcase
   endfunction

endpackage

// File: rtl/scale_ctrl_mapper.sv
// -----------------------------------------------------------------------------
// scale_ctrl_mapper
// Combinational raster-to-frame-buffer coordinate mapper. Shifts the raster
// position down according to the scale mode and reports whether the position
// lies inside the scaled frame-buffer window.
// Ports:
//   mode      - committed scale mode (2'b01 handled as 1x)
//   hcount    - raster horizontal position
//   vcount    - raster vertical position
//   h_scaled  - horizontal frame-buffer coordinate
//   v_scaled  - vertical frame-buffer coordinate
//   in_window - raster position maps onto a frame-buffer pixel
// -----------------------------------------------------------------------------
module scale_ctrl_mapper
   import scale_pkg::*;
#(
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
   input  logic [1:0]  mode,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic [10:0] h_scaled,
   output logic [9:0]  v_scaled,
   output logic        in_window
);

   always_comb begin
      h_scaled  = hcount;
      v_scaled  = vcount;
      in_window = (32'(hcount) < FB_WIDTH) && (32'(vcount) < FB_HEIGHT);
      case (mode)
         SCALE_2X: begin
            h_scaled  = hcount >> 1;
            v_scaled  = vcount >> 1;
            in_window = (32'(hcount) < 2 * FB_WIDTH) && (32'(vcount) < 2 * FB_HEIGHT);
         end
         SCALE_4H2V: begin
            h_scaled  = hcount >> 2;
            v_scaled  = vcount >> 1;
            in_window = (32'(hcount) < 4 * FB_WIDTH) && (32'(vcount) < 2 * FB_HEIGHT);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/scale_ctrl.sv
// -----------------------------------------------------------------------------
// scale_ctrl
// Display scale controller. A rising edge on step_in requests the next scale
// mode; requests are accumulated and committed at the next frame boundary on
// which no capture is in progress. The committed mode drives a two-stage
// frame-buffer read-address pipeline.
// Ports:
//   clk_in            - clock, rising edge
//   rst_in            - synchronous active-high reset
//   step_in           - debounced request level; each rising edge is a request
//   busy_in           - capture in progress, blocks commits
//   hcount_in         - raster horizontal position
//   vcount_in         - raster vertical position
//   new_frame_in      - one-cycle frame-boundary pulse
//   scale_out         - committed scale mode
//   scale_changed_out - one-cycle pulse while the commit happens
//   pending_out       - request waiting for (or undergoing) commit
//   addr_out          - frame-buffer read address, 0 when not valid
//   addr_valid_out    - qualifies addr_out
// -----------------------------------------------------------------------------
module scale_ctrl
   import scale_pkg::*;
#(
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        step_in,
   input  logic        busy_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        new_frame_in,
   output logic [1:0]  scale_out,
   output logic        scale_changed_out,
   output logic        pending_out,
   output logic [16:0] addr_out,
   output logic        addr_valid_out
);

   state_t      state, state_nxt;
   logic [1:0]  target, target_nxt;
   logic [1:0]  scale_nxt;
   logic        step_q;
   logic        req;

   assign req = step_in & ~step_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= IDLE;
         target    <= SCALE_1X;
         scale_out <= SCALE_1X;
         step_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         target    <= target_nxt;
         scale_out <= scale_nxt;
         step_q    <= step_in;
      end
   end

   // A request arriving in the same cycle as the frame boundary is folded
   // into the target before it commits.
   always_comb begin
      state_nxt         = state;
      target_nxt        = target;
      scale_nxt         = scale_out;
      scale_changed_out = 1'b0;
      pending_out       = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               target_nxt = next_scale(scale_out);
               state_nxt  = PENDING;
            end
         end
         PENDING: begin
            pending_out = 1'b1;
            if (req) target_nxt = next_scale(target);
            if (new_frame_in && !busy_in) state_nxt = COMMIT;
         end
         COMMIT: begin
            pending_out       = 1'b1;
            scale_changed_out = 1'b1;
            scale_nxt         = target;
            if (req) begin
               target_nxt = next_scale(target);
               state_nxt  = PENDING;
            end else begin
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   logic [10:0] h_scaled;
   logic [9:0]  v_scaled;
   logic        in_window;

   scale_ctrl_mapper #(
      .FB_WIDTH  (FB_WIDTH),
      .FB_HEIGHT (FB_HEIGHT)
   ) u_mapper (
      .mode      (scale_out),
      .hcount    (hcount_in),
      .vcount    (vcount_in),
      .h_scaled  (h_scaled),
      .v_scaled  (v_scaled),
      .in_window (in_window)
   );

   // Stage 1: scaled coordinates and window test
   logic [10:0] h_scaled_p1;
   logic [9:0]  v_scaled_p1;
   logic        vld_p1;

   always_ff @(posedge clk_in) begin
      h_scaled_p1 <= h_scaled;
      v_scaled_p1 <= v_scaled;
      if (rst_in) vld_p1 <= 1'b0;
      else        vld_p1 <= in_window;
   end

   // Stage 2: linear address, forced to zero outside the window
   logic [16:0] addr_p2;
   logic        vld_p2;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_p2 <= '0;
         vld_p2  <= 1'b0;
      end else begin
         addr_p2 <= vld_p1 ? (17'(v_scaled_p1) * 17'(FB_WIDTH) + 17'(h_scaled_p1)) : '0;
         vld_p2  <= vld_p1;
      end
   end

   assign addr_out       = addr_p2;
   assign addr_valid_out = vld_p2;

endmodule

// File: tb/tb_scale_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scale_ctrl
// Directed testbench for scale_ctrl: reset defaults, single request, request
// stacking, busy blocking, address pipeline and reset during a pending request.
// -----------------------------------------------------------------------------
module tb_scale_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        step = 1'b0;
   logic        busy = 1'b0;
   logic [10:0] hcount = '0;
   logic [9:0]  vcount = '0;
   logic        new_frame = 1'b0;
   logic [1:0]  scale;
   logic        changed;
   logic        pending;
   logic [16:0] addr;
   logic        addr_valid;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   scale_ctrl dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .step_in           (step),
      .busy_in           (busy),
      .hcount_in         (hcount),
      .vcount_in         (vcount),
      .new_frame_in      (new_frame),
      .scale_out         (scale),
      .scale_changed_out (changed),
      .pending_out       (pending),
      .addr_out          (addr),
      .addr_valid_out    (addr_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (changed === 1'b1) pulses++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic request();
      step = 1'b1; tick(1);
      step = 1'b0; tick(1);
   endtask

   task automatic frame();
      new_frame = 1'b1; tick(1);
      new_frame = 1'b0; tick(1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; tick(n);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      step = 1'b1; tick(1);
      do_reset(3);
      step = 1'b0;
      checks++; if (scale !== 2'b00) begin failures++; $display("FAIL reset_scale got=%b exp=00", scale); end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
      checks++; if (addr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", addr_valid); end
      checks++; if (addr !== 17'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr); end
      checks++; if (changed !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", changed); end
      tick(1);
   endtask

   task automatic test_single();
      pulses = 0;
      step = 1'b1; tick(10);
      step = 1'b0;
      checks++; if (pending !== 1'b1) begin failures++; $display("FAIL single_pending got=%b exp=1", pending); end
      tick(1);
      new_frame = 1'b1; tick(1);
      new_frame = 1'b0;
      checks++; if (changed !== 1'b1) begin failures++; $display("FAIL single_pulse_now got=%b exp=1", changed); end
      tick(3);
      checks++; if (scale !== 2'b11) begin failures++; $display("FAIL single_scale got=%b exp=11", scale); end
      checks++; if (pulses !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL single_pending_clr got=%b exp=0", pending); end
   endtask

   task automatic test_stacking();
      do_reset(2);
      pulses = 0;
      request(); request(); request();
      checks++; if (scale !== 2'b00 || pending !== 1'b1) begin failures++; $display("FAIL stack_before got=%b/%b exp=00/1", scale, pending); end
      frame(); tick(2);
      checks++; if (scale !== 2'b00) begin failures++; $display("FAIL stack_scale got=%b exp=00", scale); end
      checks++; if (pulses !== 1) begin failures++; $display("FAIL stack_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_busy();
      pulses = 0;
      request();
      busy = 1'b1;
      frame(); tick(2);
      checks++; if (pending !== 1'b1) begin failures++; $display("FAIL busy_pending got=%b exp=1", pending); end
      checks++; if (scale !== 2'b00) begin failures++; $display("FAIL busy_scale got=%b exp=00", scale); end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL busy_pulses got=%0d exp=0", pulses); end
      busy = 1'b0;
      frame(); tick(1);
      checks++; if (scale !== 2'b11) begin failures++; $display("FAIL busy_commit_scale got=%b exp=11", scale); end
      checks++; if (pulses !== 1) begin failures++; $display("FAIL busy_commit_pulses got=%0d exp=1", pulses); end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL busy_pending_clr got=%b exp=0", pending); end
   endtask

   task automatic test_addr_4h2v();
      request(); frame(); tick(1);
      checks++; if (scale !== 2'b10) begin failures++; $display("FAIL addr_mode got=%b exp=10", scale); end
      hcount = 11'd963; vcount = 10'd5; tick(2);
      checks++; if (addr_valid !== 1'b0) begin failures++; $display("FAIL addr_out_valid got=%b exp=0", addr_valid); end
      checks++; if (addr !== 17'd0) begin failures++; $display("FAIL addr_out_zero got=%0d exp=0", addr); end
      hcount = 11'd959; vcount = 10'd639; tick(1);
      checks++; if (addr_valid !== 1'b0) begin failures++; $display("FAIL addr_latency got=%b exp=0", addr_valid); end
      tick(1);
      checks++; if (addr !== 17'd76799) begin failures++; $display("FAIL addr_max got=%0d exp=76799", addr); end
      checks++; if (addr_valid !== 1'b1) begin failures++; $display("FAIL addr_max_valid got=%b exp=1", addr_valid); end
      hcount = 11'd4; vcount = 10'd2; tick(2);
      checks++; if (addr !== 17'd241 || addr_valid !== 1'b1) begin failures++; $display("FAIL addr_small got=%0d/%b exp=241/1", addr, addr_valid); end
   endtask

   task automatic test_reset_mid();
      pulses = 0;
      request();
      checks++; if (pending !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", pending); end
      do_reset(1);
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL mid_pending_clr got=%b exp=0", pending); end
      checks++; if (scale !== 2'b00) begin failures++; $display("FAIL mid_scale got=%b exp=00", scale); end
      frame(); tick(2);
      checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_pulses got=%0d exp=0", pulses); end
      checks++; if (scale !== 2'b00) begin failures++; $display("FAIL mid_scale_after got=%b exp=00", scale); end
   endtask

   task automatic test_addr_1x();
      hcount = 11'd239; vcount = 10'd319; tick(2);
      checks++; if (addr !== 17'd76799 || addr_valid !== 1'b1) begin failures++; $display("FAIL addr1x_max got=%0d/%b exp=76799/1", addr, addr_valid); end
      hcount = 11'd240; vcount = 10'd0; tick(2);
      checks++; if (addr !== 17'd0 || addr_valid !== 1'b0) begin failures++; $display("FAIL addr1x_hedge got=%0d/%b exp=0/0", addr, addr_valid); end
      hcount = 11'd10; vcount = 10'd320; tick(2);
      checks++; if (addr !== 17'd0 || addr_valid !== 1'b0) begin failures++; $display("FAIL addr1x_vedge got=%0d/%b exp=0/0", addr, addr_valid); end
      hcount = 11'd7; vcount = 10'd3; tick(2);
      checks++; if (addr !== 17'd727 || addr_valid !== 1'b1) begin failures++; $display("FAIL addr1x_mid got=%0d/%b exp=727/1", addr, addr_valid); end
   endtask

   initial begin
      tick(1);
      test_reset();
      test_single();
      test_stacking();
      test_busy();
      test_addr_4h2v();
      test_reset_mid();
      test_addr_1x();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scale_ctrl.md
SCALE_CTRL -- requirements
Module: scale_ctrl

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 240, meaning frame-buffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 320, meaning frame-buffer height in pixels.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port step_in, input, 1, cycle-scale request as a level from the debouncer; a rising edge is one request.
REQ-006 SHALL have port busy_in, input, 1, capture in progress; while high, no scale change may commit.
REQ-007 SHALL have ports hcount_in (input, 11) and vcount_in (input, 10), the raster position.
REQ-008 SHALL have port new_frame_in, input, 1, a one-cycle pulse at the frame boundary.
REQ-009 SHALL have port scale_out, output, 2, the committed scale mode.
REQ-010 SHALL have port scale_changed_out, output, 1, a one-cycle pulse in the cycle scale_out changes.
REQ-011 SHALL have port pending_out, output, 1, high while a request awaits commit.
REQ-012 SHALL have port addr_out, output, 17, the frame-buffer read address.
REQ-013 SHALL have port addr_valid_out, output, 1, qualifies addr_out.

Function
REQ-014 SHALL use these mode encodings:
- 2'b00: 1x, h and v unshifted, window h<240, v<320.
- 2'b11: 2x, h>>1, v>>1, window h<480, v<640.
- 2'b10: 4x horizontal / 2x vertical, h>>2, v>>1, window h<960, v<640.
- 2'b01: never produced; if decoded, treated as 2'b00.
REQ-015 SHALL step modes in the order 00 -> 11 -> 10 -> 00, wrapping around.
REQ-016 SHALL detect a request as step_in high in this cycle and low in the previous registered cycle; the level is held high for multiple cycles counts as one request.
REQ-017 SHALL implement an FSM with states IDLE, PENDING and COMMIT:
- IDLE -> PENDING on a request; target = next(scale_out).
- PENDING with a further request: target = next(target), state stays PENDING.
- PENDING -> COMMIT when new_frame_in=1 and busy_in=0.
- COMMIT lasts one cycle: scale_out <= target, scale_changed_out=1, then IDLE.
REQ-018 SHALL, on a request arriving during COMMIT, set target = next(committed target) and go to PENDING instead of IDLE.
REQ-019 SHALL, on new_frame_in while busy_in=1, keep PENDING and wait for a later frame boundary.
REQ-020 SHALL assert pending_out in both PENDING and COMMIT.
REQ-021 SHALL form the address in a 2-stage pipeline using the committed scale_out:
- Stage 1 registers the scaled h, the scaled v and the window test.
- Stage 2 registers addr_out = scaled_v*FB_WIDTH + scaled_h and addr_valid_out.
- Total latency: 2 cycles from hcount_in/vcount_in.
REQ-022 SHALL compute the address at 17-bit width with no truncation; the maximum legal value is 76799.
REQ-023 SHALL drive addr_out to 0 whenever addr_valid_out is 0.
REQ-024 SHALL let a commit take effect on stage 1 in the cycle after scale_changed_out; pipeline contents already in flight keep the old mode.

Reset
REQ-025 SHALL, when rst_in is high, set state=IDLE, scale_out=2'b00, target=2'b00, scale_changed_out=0, pending_out=0, addr_out=0, addr_valid_out=0 and the edge-detect register=0.
REQ-026 SHALL let reset during PENDING or COMMIT discard the request, with no commit pulse.

Structure
REQ-027 SHALL place the mode encodings, the next-mode function, FB_WIDTH/FB_HEIGHT defaults and the FSM state enum in shared package scale_pkg.
REQ-028 SHALL instance the existing combinational scale mapper as its single sub-module for stage 1.

Verification
REQ-029 SHALL test reset defaults: assert rst_in for 3 cycles -> scale_out=00, pending_out=0, addr_valid_out=0.
REQ-030 SHALL test a single request: step_in held high 10 cycles, then new_frame_in pulse with busy_in=0 -> exactly one scale_changed_out pulse and scale_out=11.
REQ-031 SHALL test request stacking: 3 separate step_in edges before one frame boundary -> scale_out=00 after wrap, with one change pulse.
REQ-032 SHALL test the busy block: request, then new_frame_in with busy_in=1 -> no change and pending_out=1; next new_frame_in with busy_in=0 -> commit.
REQ-033 SHALL test the address path: mode 10 with h=963, v=5 -> addr_valid_out=0, addr_out=0; h=959, v=639 -> 2 cycles later addr_out=76799, addr_valid_out=1.
REQ-034 SHALL test reset mid-operation: rst_in during PENDING -> pending cleared, scale_out=00, and no pulse at the next frame boundary.
